dtu_stream: RTL and testbench

- Parametrised successor of the DNA translation unit (dtu).
- Accepts DIN_W-bit packed words (default 32-bit = 16 two-bit bases) through a DEPTH-entry input FIFO.
- Serialises each word into SYM_W-bit symbols with valid/ready on both sides, selectable symbol order, partial final words and an emitted-symbol counter.
- Sits between the host/DMA word stream and the per-base matching pipeline.

---
 rtl/dtu_stream.sv | 156 +++++++++++++++
 tb/tb_dtu_stream.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dtu_stream.sv
// Word-to-symbol serialiser: buffers packed DIN_W-bit words in a small FIFO and
// streams them out SYM_W bits at a time with valid/ready on both sides.
//
// state | meaning
// IDLE  | shift register empty, waiting for a FIFO entry
// SHIFT | presenting symbols of the loaded word on dout
module dtu_stream #(
    parameter int DIN_W     = 32,
    parameter int SYM_W     = 2,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 0,
    localparam int SYMS     = DIN_W / SYM_W,
    localparam int NS_W     = $clog2(SYMS),
    localparam int LV_W     = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIN_W-1:0] din,
    input  logic             din_valid,
    input  logic             din_last,
    input  logic [NS_W-1:0]  din_nsym,
    output logic             din_ready,
    output logic [SYM_W-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_last,
    output logic [LV_W-1:0]  fifo_level,
    output logic [31:0]      sym_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int RW = NS_W + 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [DIN_W-1:0] mem_data [DEPTH];
    logic             mem_last [DEPTH];
    logic [NS_W-1:0]  mem_nsym [DEPTH];

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LV_W-1:0]  level;

    state_t           state;
    logic [DIN_W-1:0] shreg;
    logic [RW-1:0]    remain;
    logic             word_last;
    logic [31:0]      count;

    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             handshake;
    logic             last_sym;
    logic [RW-1:0]    head_remain;

    // rst gates din_ready so the input side reads "not ready" for the whole reset window
    assign din_ready  = rst & en & (level != LV_W'(DEPTH));
    assign push       = din_valid & din_ready;
    assign fifo_empty = (level == '0);

    assign dout_valid = en & (state == SHIFT);
    assign handshake  = dout_valid & dout_ready;
    assign last_sym   = (remain == RW'(1));
    assign dout_last  = dout_valid & word_last & last_sym;

    // pop on IDLE, or on the final symbol's handshake for a zero-bubble word boundary
    assign pop = en & ~fifo_empty & ((state == IDLE) | (handshake & last_sym));

    always_comb begin
        head_remain = RW'(SYMS);
        if (mem_last[rd_ptr] && (mem_nsym[rd_ptr] != '0))
            head_remain = {1'b0, mem_nsym[rd_ptr]};
    end

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign dout = shreg[DIN_W-1 -: SYM_W];
        end else begin : g_lsb
            assign dout = shreg[SYM_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= din;
            mem_last[wr_ptr] <= din_last;
            mem_nsym[wr_ptr] <= din_nsym;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LV_W'(1);
                2'b01:   level <= level - LV_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shreg     <= '0;
            remain    <= '0;
            word_last <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg     <= mem_data[rd_ptr];
                        word_last <= mem_last[rd_ptr];
                        remain    <= head_remain;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (handshake) begin
                        if (!last_sym) begin
                            shreg  <= (MSB_FIRST != 0) ? (shreg << SYM_W) : (shreg >> SYM_W);
                            remain <= remain - RW'(1);
                        end else if (pop) begin
                            shreg     <= mem_data[rd_ptr];
                            word_last <= mem_last[rd_ptr];
                            remain    <= head_remain;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (handshake && (count != '1))
            count <= count + 32'd1;
    end

    assign fifo_level = level;
    assign sym_count  = count;

endmodule

// File: tb/tb_dtu_stream.sv
// Bench for dtu_stream: LSB-first and MSB-first instances share stimulus; a
// per-instance scoreboard queue holds expected {last, symbol} pairs.
module tb_dtu_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] din;
    logic        din_valid;
    logic        din_last;
    logic [3:0]  din_nsym;
    logic        dout_ready;

    logic        din_ready_l, dout_valid_l, dout_last_l;
    logic [1:0]  dout_l;
    logic [2:0]  fifo_level_l;
    logic [31:0] sym_count_l;

    logic        din_ready_m, dout_valid_m, dout_last_m;
    logic [1:0]  dout_m;
    logic [2:0]  fifo_level_m;
    logic [31:0] sym_count_m;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    logic [2:0] q_l [$];
    logic [2:0] q_m [$];

    always #5 clk = ~clk;

    dtu_stream #(.MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
        .din_last(din_last), .din_nsym(din_nsym), .din_ready(din_ready_l),
        .dout(dout_l), .dout_valid(dout_valid_l), .dout_ready(dout_ready),
        .dout_last(dout_last_l), .fifo_level(fifo_level_l), .sym_count(sym_count_l)
    );

    dtu_stream #(.MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
        .din_last(din_last), .din_nsym(din_nsym), .din_ready(din_ready_m),
        .dout(dout_m), .dout_valid(dout_valid_m), .dout_ready(dout_ready),
        .dout_last(dout_last_m), .fifo_level(fifo_level_m), .sym_count(sym_count_m)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w, input logic lst, input logic [3:0] ns);
        int n;
        int waited;
        din       = w;
        din_last  = lst;
        din_nsym  = ns;
        din_valid = 1'b1;
        waited    = 0;
        while (!din_ready_l && waited < 300) begin
            tick();
            waited++;
        end
        chk("push_ready", {31'd0, din_ready_l}, 32'd1);
        if (din_ready_l) begin
            n = (lst && ns != 4'd0) ? int'(ns) : 16;
            for (int i = 0; i < n; i++) begin
                q_l.push_back({(lst && i == n - 1), 2'((w >> (2 * i)) & 32'd3)});
                q_m.push_back({(lst && i == n - 1), 2'((w >> (30 - 2 * i)) & 32'd3)});
            end
            exp_cnt += n;
        end
        tick();
        din_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while ((q_l.size() != 0 || q_m.size() != 0) && waited < 2000) begin
            tick();
            waited++;
        end
        tick();
        chk("drain_left", q_l.size() + q_m.size(), 32'd0);
    endtask

    // scoreboard: compare every accepted symbol against the queued expectation
    always @(negedge clk) begin
        if (rst && dout_ready) begin
            if (dout_valid_l) begin
                if (q_l.size() == 0) chk("lsb_unexp", {31'd0, dout_valid_l}, 32'd0);
                else chk("lsb_sym", {29'd0, dout_last_l, dout_l}, {29'd0, q_l.pop_front()});
            end
            if (dout_valid_m) begin
                if (q_m.size() == 0) chk("msb_unexp", {31'd0, dout_valid_m}, 32'd0);
                else chk("msb_sym", {29'd0, dout_last_m, dout_m}, {29'd0, q_m.pop_front()});
            end
        end
    end

    initial begin
        logic [1:0]  held_l;
        logic [31:0] base;
        int          v;
        int          waited;

        rst = 1'b0; en = 1'b1; din = '0; din_valid = 1'b0;
        din_last = 1'b0; din_nsym = '0; dout_ready = 1'b1;

        // reset values
        #2;
        chk("rst_din_ready", {31'd0, din_ready_l}, 32'd0);
        chk("rst_dout_valid", {31'd0, dout_valid_l}, 32'd0);
        chk("rst_dout", {30'd0, dout_l}, 32'd0);
        chk("rst_dout_last", {31'd0, dout_last_l}, 32'd0);
        chk("rst_level", {29'd0, fifo_level_l}, 32'd0);
        chk("rst_count", sym_count_l, 32'd0);
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("rel_din_ready", {31'd0, din_ready_l}, 32'd1);

        // single full word, latency then drain
        push_word(32'h0000_001B, 1'b1, 4'd0);
        chk("lat_e0_valid", {31'd0, dout_valid_l}, 32'd0);
        tick();
        chk("lat_e1_valid", {31'd0, dout_valid_l}, 32'd1);
        chk("lat_e1_msb_valid", {31'd0, dout_valid_m}, 32'd1);
        drain();
        chk("w1_count_l", sym_count_l, 32'd16);
        chk("w1_count_m", sym_count_m, 32'd16);
        chk("w1_idle", {31'd0, dout_valid_l}, 32'd0);

        // backpressure: fill shifter + FIFO
        dout_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push_word($urandom, (i == 4), 4'd0);
        tick();
        chk("full_level", {29'd0, fifo_level_l}, 32'd4);
        chk("full_ready", {31'd0, din_ready_l}, 32'd0);
        held_l = dout_l;
        din = 32'hDEAD_BEEF; din_last = 1'b0; din_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("full_ready2", {31'd0, din_ready_l}, 32'd0);
        chk("full_level2", {29'd0, fifo_level_m}, 32'd4);
        chk("hold_dout", {30'd0, dout_l}, {30'd0, held_l});
        chk("hold_valid", {31'd0, dout_valid_l}, 32'd1);
        din_valid = 1'b0;
        dout_ready = 1'b1;
        v = 0;
        for (int i = 0; i < 80; i++) begin
            if (dout_valid_l) v++;
            tick();
        end
        chk("stream_80", v, 32'd80);
        chk("stream_end", {31'd0, dout_valid_l}, 32'd0);
        drain();
        chk("bp_count", sym_count_l, exp_cnt);

        // partial last word
        push_word(32'hFFFF_FFE4, 1'b1, 4'd3);
        drain();
        chk("part_count", sym_count_l, exp_cnt);
        chk("part_idle", {31'd0, dout_valid_m}, 32'd0);
        chk("part_level", {29'd0, fifo_level_l}, 32'd0);

        // enable drop after 5 symbols
        base = sym_count_l;
        push_word(32'h1234_5678, 1'b1, 4'd0);
        waited = 0;
        while (sym_count_l != base + 32'd5 && waited < 100) begin
            tick();
            waited++;
        end
        en = 1'b0;
        #1;
        chk("en_ready", {31'd0, din_ready_l}, 32'd0);
        v = 0;
        for (int i = 0; i < 10; i++) begin
            if (dout_valid_l || dout_valid_m) v++;
            tick();
        end
        chk("en_valid_cycles", v, 32'd0);
        chk("en_count_hold", sym_count_l, base + 32'd5);
        en = 1'b1;
        drain();
        chk("en_count", sym_count_l, exp_cnt);

        // async reset mid-word with FIFO contents pending
        dout_ready = 1'b0;
        push_word(32'hAAAA_5555, 1'b0, 4'd0);
        push_word(32'h0F0F_F0F0, 1'b0, 4'd0);
        push_word(32'h1357_9BDF, 1'b1, 4'd0);
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b0;
        #1;
        q_l.delete();
        q_m.delete();
        exp_cnt = 0;
        chk("arst_valid", {31'd0, dout_valid_l}, 32'd0);
        chk("arst_dout", {30'd0, dout_l}, 32'd0);
        chk("arst_level", {29'd0, fifo_level_l}, 32'd0);
        chk("arst_count", sym_count_m, 32'd0);
        chk("arst_ready", {31'd0, din_ready_l}, 32'd0);
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("arst_rel_ready", {31'd0, din_ready_l}, 32'd1);
        tick(); tick();
        chk("arst_quiet", {31'd0, dout_valid_l}, 32'd0);
        push_word(32'h8421_C63A, 1'b1, 4'd7);
        drain();
        chk("new_count", sym_count_l, exp_cnt);
        chk("new_idle", {31'd0, dout_valid_l}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
